// File: rtl/hsid_x_ctrl_if.sv
// Band-fetch / MSE handshake bundle between the run-control sequencer and
// the band-fetch/MSE datapath.
//   master (sequencer): drives band_valid/band_cap_addr/band_lib_addr/band_last,
//                       receives band_ready and the per-pixel mse_valid/mse_value.
//   slave  (datapath) : the mirror image.
interface hsid_x_ctrl_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  band_valid;
  logic                  band_ready;
  logic [WORD_WIDTH-1:0] band_cap_addr;
  logic [WORD_WIDTH-1:0] band_lib_addr;
  logic                  band_last;
  logic                  mse_valid;
  logic [WORD_WIDTH-1:0] mse_value;

  modport master (
    output band_valid, band_cap_addr, band_lib_addr, band_last,
    input  band_ready, mse_valid, mse_value
  );

  modport slave (
    input  band_valid, band_cap_addr, band_lib_addr, band_last,
    output band_ready, mse_valid, mse_value
  );
endinterface

// File: rtl/hsid_x_ctrl.sv
// HSpecID-X run-control sequencer.
// Takes start/clear pulses and the job configuration from the register
// block, walks every library pixel band by band issuing (captured, library)
// word-address pairs to the band-fetch/MSE datapath, tracks the min/max MSE
// over the library and reports status plus a one-cycle completion pulse.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start_i, clear_i           one-cycle command pulses
//   library_size_i             pixels in the library (sampled at start)
//   pixel_bands_i              bands per pixel (sampled at start)
//   captured_pixel_addr_i      byte address of captured pixel band 0
//   library_pixel_addr_i       byte address of library pixel 0 band 0
//   idle_o/ready_o             high while no job runs
//   done_o/error_o/cancelled_o sticky job outcome, cleared by start or clear
//   interruption_o             one-cycle pulse on completion/error/cancel
//   mse_min_ref_o/_value_o     library index and value of minimum MSE
//   mse_max_ref_o/_value_o     library index and value of maximum MSE
//   band_if                    band address stream out, MSE results in
module hsid_x_ctrl #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 12,
  parameter int HSP_LIBRARY_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         clear_i,
  input  logic [HSP_LIBRARY_WIDTH-1:0] library_size_i,
  input  logic [HSP_BANDS_WIDTH-1:0]   pixel_bands_i,
  input  logic [WORD_WIDTH-1:0]        captured_pixel_addr_i,
  input  logic [WORD_WIDTH-1:0]        library_pixel_addr_i,
  output logic                         idle_o,
  output logic                         ready_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic                         cancelled_o,
  output logic                         interruption_o,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref_o,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref_o,
  output logic [WORD_WIDTH-1:0]        mse_min_value_o,
  output logic [WORD_WIDTH-1:0]        mse_max_value_o,
  hsid_x_ctrl_if.master                band_if
);

  localparam int WW  = WORD_WIDTH;
  localparam int HBW = HSP_BANDS_WIDTH;
  localparam int HLW = HSP_LIBRARY_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_MSE,
    S_FINISH
  } state_t;

  state_t         state_q;
  logic [HLW-1:0] pix_q;
  logic [HBW-1:0] band_q;
  logic [WW-1:0]  cap_ptr_q;
  logic [WW-1:0]  lib_ptr_q;
  logic [WW-1:0]  cap_base_q;
  logic [HLW-1:0] lib_size_q;
  logic [HBW-1:0] bands_q;
  logic           trk_vld_q;
  logic           idle_q, ready_q, done_q, error_q, cancelled_q, irq_q;
  logic [HLW-1:0] min_ref_q, max_ref_q;
  logic [WW-1:0]  min_val_q, max_val_q;
  logic           band_valid_q, band_last_q;

  logic           cfg_bad;
  logic           handshake;
  logic [HBW-1:0] band_d;
  logic           pix_last;
  logic           single_band;
  logic           min_upd, max_upd;

  assign cfg_bad     = (library_size_i == '0) || (pixel_bands_i == '0) ||
                       (captured_pixel_addr_i[1:0] != 2'b00) ||
                       (library_pixel_addr_i[1:0] != 2'b00);
  assign handshake   = band_valid_q & band_if.band_ready;
  assign band_d      = band_q + HBW'(1);
  assign pix_last    = (pix_q == lib_size_q - HLW'(1));
  assign single_band = (bands_q == HBW'(1));
  // First result loads both trackers; strict compares keep the lower index on ties.
  assign min_upd     = !trk_vld_q || (band_if.mse_value < min_val_q);
  assign max_upd     = !trk_vld_q || (band_if.mse_value > max_val_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pix_q        <= '0;
      band_q       <= '0;
      cap_ptr_q    <= '0;
      lib_ptr_q    <= '0;
      cap_base_q   <= '0;
      lib_size_q   <= '0;
      bands_q      <= '0;
      trk_vld_q    <= 1'b0;
      idle_q       <= 1'b1;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cancelled_q  <= 1'b0;
      irq_q        <= 1'b0;
      min_ref_q    <= '0;
      max_ref_q    <= '0;
      min_val_q    <= '0;
      max_val_q    <= '0;
      band_valid_q <= 1'b0;
      band_last_q  <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (clear_i) begin
        // Abort a running job; in IDLE only the sticky status is wiped.
        if (state_q != S_IDLE) begin
          cancelled_q <= 1'b1;
          irq_q       <= 1'b1;
        end else begin
          done_q      <= 1'b0;
          error_q     <= 1'b0;
          cancelled_q <= 1'b0;
        end
        state_q      <= S_IDLE;
        idle_q       <= 1'b1;
        ready_q      <= 1'b1;
        band_valid_q <= 1'b0;
        band_last_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              done_q      <= 1'b0;
              cancelled_q <= 1'b0;
              if (cfg_bad) begin
                error_q <= 1'b1;
                irq_q   <= 1'b1;
              end else begin
                error_q      <= 1'b0;
                state_q      <= S_ISSUE;
                idle_q       <= 1'b0;
                ready_q      <= 1'b0;
                pix_q        <= '0;
                band_q       <= '0;
                cap_ptr_q    <= captured_pixel_addr_i;
                cap_base_q   <= captured_pixel_addr_i;
                lib_ptr_q    <= library_pixel_addr_i;
                lib_size_q   <= library_size_i;
                bands_q      <= pixel_bands_i;
                trk_vld_q    <= 1'b0;
                band_valid_q <= 1'b1;
                band_last_q  <= (pixel_bands_i == HBW'(1));
              end
            end
          end
          S_ISSUE: begin
            if (handshake) begin
              // Library pointer never rewinds: pixels are stored back to back.
              lib_ptr_q <= lib_ptr_q + WW'(4);
              if (band_last_q) begin
                state_q      <= S_WAIT_MSE;
                band_valid_q <= 1'b0;
                band_last_q  <= 1'b0;
                band_q       <= '0;
                cap_ptr_q    <= cap_base_q;
              end else begin
                band_q      <= band_d;
                cap_ptr_q   <= cap_ptr_q + WW'(4);
                band_last_q <= (band_d == bands_q - HBW'(1));
              end
            end
          end
          S_WAIT_MSE: begin
            if (band_if.mse_valid) begin
              trk_vld_q <= 1'b1;
              if (min_upd) begin
                min_ref_q <= pix_q;
                min_val_q <= band_if.mse_value;
              end
              if (max_upd) begin
                max_ref_q <= pix_q;
                max_val_q <= band_if.mse_value;
              end
              if (pix_last) begin
                state_q <= S_FINISH;
                irq_q   <= 1'b1;
                done_q  <= 1'b1;
              end else begin
                pix_q        <= pix_q + HLW'(1);
                state_q      <= S_ISSUE;
                band_valid_q <= 1'b1;
                band_last_q  <= single_band;
              end
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
            idle_q  <= 1'b1;
            ready_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign idle_o          = idle_q;
  assign ready_o         = ready_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign cancelled_o     = cancelled_q;
  assign interruption_o  = irq_q;
  assign mse_min_ref_o   = min_ref_q;
  assign mse_max_ref_o   = max_ref_q;
  assign mse_min_value_o = min_val_q;
  assign mse_max_value_o = max_val_q;

  assign band_if.band_valid    = band_valid_q;
  assign band_if.band_cap_addr = cap_ptr_q;
  assign band_if.band_lib_addr = lib_ptr_q;
  assign band_if.band_last     = band_last_q;

endmodule
